modexp_ctrl: RTL and testbench
==============================

# modexp_ctrl

Square-and-multiply sequencer for the 16-bit modular exponentiation datapath. It accepts one (base, exponent, modulus) job at a time. It first runs the Montgomery setup unit to obtain p = R² mod n, with R = 2^WIDTH. It then drives a shared Montgomery multiplier through domain conversion, the exponent scan and the final conversion back, and returns base^exp mod n. It sits between the host/top-level handshake and the mm_setup and Montgomery multiplier instances.

## Interface
- WIDTH, 16, operand, modulus and exponent width in bits.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- n  in  WIDTH  modulus; latched on an accepted start.
- base  in  WIDTH  base; latched on an accepted start; must be < n.
- exp  in  WIDTH  exponent; latched on an accepted start.
- result  out  WIDTH  base^exp mod n; valid from the done pulse until the next accepted start.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  modulus rejected; valid with done.
- setup_rst  out  1  reset to mm_setup; high except in SETUP.
- setup_ce  out  1  enable to mm_setup; high only in SETUP.
- setup_n  out  WIDTH  latched modulus.
- setup_p  in  WIDTH  R² mod n from mm_setup.
- setup_ready  in  1  setup_p valid.
- mm_start  out  1  one-cycle multiply request.
- mm_a, mm_b  out  WIDTH  multiplier operands; held stable until mm_done.
- mm_n  out  WIDTH  latched modulus.
- mm_done  in  1  one-cycle multiply completion; mm_r is valid in the same cycle.
- mm_r  in  WIDTH  a·b·R⁻¹ mod n.

## Operation
- Reset state: IDLE. result=0, busy=0, done=0, err=0, setup_rst=1, setup_ce=0, mm_start=0, mm_a=0, mm_b=0.
- Registers: acc, xbar, p_reg, bit index i (log2 WIDTH bits), latched n/base/exp.
- **IDLE**
  - On start: latch the inputs and set busy.
  - If n is even or n < 3: go to DONE with err=1 and result=0. No setup or multiply operation is issued.
  - Otherwise go to SETUP.
- **SETUP**
  - setup_rst=0 and setup_ce=1.
  - On setup_ready: capture p_reg=setup_p and go to TOBASE.
- **TOBASE**
  - Issue MM(base, p_reg).
  - On mm_done: xbar=mm_r.
- **TOONE**
  - Issue MM(1, p_reg).
  - On mm_done: acc=mm_r (R mod n). Set i=WIDTH-1.
- **SQR**
  - Issue MM(acc, acc).
  - On mm_done: acc=mm_r.
  - If exp[i]=1, go to MUL. Otherwise, if i=0 go to FROM, else decrement i and stay in SQR.
- **MUL**
  - Issue MM(acc, xbar).
  - On mm_done: acc=mm_r.
  - If i=0 go to FROM, else decrement i and go to SQR.
- **FROM**
  - Issue MM(acc, 1).
  - On mm_done: result=mm_r. Go to DONE.
- **DONE**
  - done=1 for one cycle, busy=0, then return to IDLE.
- Multiply-issue rule: mm_start pulses in the first cycle of each multiply state. The state then waits for mm_done. mm_done is ignored outside a waiting multiply state.
- Multiply count per job: 2 + WIDTH + popcount(exp) + 1.
- exp=0: result=1.
- start while busy: ignored. Inputs are not re-latched.
- Reset mid-job: immediate return to IDLE with reset output values. Any in-flight multiply result is discarded.

## Timing
- Accepted start at cycle t: busy=1 and setup_rst=0 at t+1.
- setup_ready at cycle s: first mm_start at s+1.
- mm_done at cycle d:
  - within a job, the next mm_start is at d+1;
  - when the last multiply completes, done=1 at d+1.
- Rejected modulus: done=1 and err=1 at t+2.
- done and busy are never high in the same cycle.
- start sampled in the done cycle is ignored; a new start is accepted one cycle after done.

## Configuration
- MODEXP_SETUP_CACHE_EN defined:
  - A valid n is stored with a valid flag; rst clears the flag.
  - If a new job's n equals the cached n, SETUP is skipped: IDLE goes straight to TOBASE and p_reg is reused.
  - setup_ce stays 0 and setup_rst stays 1 for that job.
  - Jobs rejected with err do not change the cache.
- MODEXP_SETUP_CACHE_EN undefined: every valid job passes through SETUP.

## Structure
- Shared package modexp_pkg holds:
  - the WIDTH default;
  - the state enum (IDLE, SETUP, TOBASE, TOONE, SQR, MUL, FROM, DONE);
  - the Montgomery constant ONE = 1.
- One sub-module: modexp_exp_scan, which holds the latched exponent, the bit index i, and the exp[i] / last-bit outputs.

## Test plan
- n=0x3317, base=2, exp=10 -> result=0x0400, err=0, exactly 2+16+2+1=21 mm_start pulses.
- n=0x3317, base=3, exp=0 -> result=0x0001, 19 mm_start pulses.
- n=0x3316, any base/exp -> done with err=1 and result=0 at t+2, no setup_ce or mm_start.
- n=0x3317, base=0x1234, exp=0xFFFF -> result matches the bench's reference modexp model; a start pulse while busy is ignored.
- Assert rst during SQR -> all outputs at reset values; the following job (base=2, exp=10, n=0x3317) still returns 0x0400.
- Two back-to-back jobs with n=0x3317:
  - with MODEXP_SETUP_CACHE_EN, the second job shows no setup_ce;
  - without it, setup_ce is asserted again;
  - both jobs return correct results.

Source files
------------

// File: rtl/modexp_pkg.sv
// modexp_pkg: definitions shared by modexp_ctrl and its sub-module.
//   WIDTH_DEF : default operand, modulus and exponent width
//   ONE       : the Montgomery "1" operand, used for conversions
//   state_e   : sequencer states
package modexp_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ONE       = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TOBASE,
    TOONE,
    SQR,
    MUL,
    FROM,
    DONE
  } state_e;

endpackage

// File: rtl/modexp_exp_scan.sv
// modexp_exp_scan: holds the latched exponent and the scan bit index.
// Ports:
//   clk, rst        clock, async active-high reset
//   load, exp_in    capture a new exponent
//   init            set the index to the MSB (WIDTH-1)
//   dec             step the index down by one
//   bit_cur         exp[i]
//   last_bit        i == 0
module modexp_exp_scan
  import modexp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] exp_in,
  input  logic             init,
  input  logic             dec,
  output logic             bit_cur,
  output logic             last_bit
);

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0]    i_q, i_d;

  always_comb begin
    exp_d = exp_q;
    i_d   = i_q;
    if (load) exp_d = exp_in;
    if (init)     i_d = IW'(WIDTH - 1);
    else if (dec) i_d = i_q - IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      i_q   <= '0;
    end else begin
      exp_q <= exp_d;
      i_q   <= i_d;
    end
  end

  assign bit_cur  = exp_q[i_q];
  assign last_bit = (i_q == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: square-and-multiply sequencer for Montgomery modular
// exponentiation. Runs mm_setup for p = R^2 mod n, then drives one shared
// Montgomery multiplier: base->domain, 1->domain, MSB-first exponent scan,
// then conversion back out.
// Optional build macro: MODEXP_SETUP_CACHE_EN -- remembers the last valid
// modulus and its p so a repeated modulus skips SETUP.
// Ports:
//   clk, rst                   clock, async active-high reset
//   start, n, base, exp        job request and operands (latched on accept)
//   result, busy, done, err    job status / result
//   setup_rst, setup_ce,
//   setup_n, setup_p,
//   setup_ready                mm_setup control and result
//   mm_start, mm_a, mm_b,
//   mm_n, mm_done, mm_r        Montgomery multiplier control and result
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             setup_rst,
  output logic             setup_ce,
  output logic [WIDTH-1:0] setup_n,
  input  logic [WIDTH-1:0] setup_p,
  input  logic             setup_ready,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_r
);

  localparam logic [WIDTH-1:0] MONT_ONE = WIDTH'(ONE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] xbar_q, xbar_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             issued_q, issued_d;

  logic mul_state, mm_ack, n_bad, cache_hit;
  logic scan_load, scan_init, scan_dec, exp_bit, last_bit;

  modexp_exp_scan #(.WIDTH(WIDTH)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .load     (scan_load),
    .exp_in   (exp),
    .init     (scan_init),
    .dec      (scan_dec),
    .bit_cur  (exp_bit),
    .last_bit (last_bit)
  );

  assign n_bad     = ~n[0] || (n < WIDTH'(3));
  assign mul_state = (state_q == TOBASE) || (state_q == TOONE) || (state_q == SQR) ||
                     (state_q == MUL) || (state_q == FROM);
  // mm_done only counts once our request is outstanding
  assign mm_ack    = mul_state && issued_q && mm_done;

`ifdef MODEXP_SETUP_CACHE_EN
  logic             cache_vld_q, cache_vld_d;
  logic [WIDTH-1:0] cache_n_q, cache_n_d;

  assign cache_hit = cache_vld_q && (n == cache_n_q);

  // p_q is only written in SETUP, so it always belongs to cache_n_q
  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_n_d   = cache_n_q;
    if ((state_q == SETUP) && !err_q && setup_ready) begin
      cache_vld_d = 1'b1;
      cache_n_d   = n_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_n_q   <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_n_q   <= cache_n_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      base_q   <= '0;
      p_q      <= '0;
      xbar_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      base_q   <= base_d;
      p_q      <= p_d;
      xbar_q   <= xbar_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
      issued_q <= issued_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    base_d    = base_q;
    p_d       = p_q;
    xbar_d    = xbar_q;
    acc_d     = acc_q;
    result_d  = result_q;
    err_d     = err_q;
    issued_d  = issued_q;
    scan_load = 1'b0;
    scan_init = 1'b0;
    scan_dec  = 1'b0;

    if (mm_start) issued_d = 1'b1;
    if (mm_ack)   issued_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d       = n;
          base_d    = base;
          scan_load = 1'b1;
          result_d  = '0;
          err_d     = n_bad;
          // A rejected modulus spends one cycle in SETUP with mm_setup held
          // in reset, which places its done pulse two cycles after start.
          if (!n_bad && cache_hit) state_d = TOBASE;
          else                     state_d = SETUP;
        end
      end
      SETUP: begin
        if (err_q) begin
          state_d = DONE;
        end else if (setup_ready) begin
          p_d     = setup_p;
          state_d = TOBASE;
        end
      end
      TOBASE: begin
        if (mm_ack) begin
          xbar_d  = mm_r;
          state_d = TOONE;
        end
      end
      TOONE: begin
        if (mm_ack) begin
          acc_d     = mm_r;
          scan_init = 1'b1;
          state_d   = SQR;
        end
      end
      SQR: begin
        if (mm_ack) begin
          acc_d = mm_r;
          if (exp_bit)       state_d = MUL;
          else if (last_bit) state_d = FROM;
          else               scan_dec = 1'b1;
        end
      end
      MUL: begin
        if (mm_ack) begin
          acc_d = mm_r;
          if (last_bit) begin
            state_d = FROM;
          end else begin
            scan_dec = 1'b1;
            state_d  = SQR;
          end
        end
      end
      FROM: begin
        if (mm_ack) begin
          result_d = mm_r;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE) && (state_q != DONE);
    done      = (state_q == DONE);
    setup_ce  = (state_q == SETUP) && !err_q;
    setup_rst = !setup_ce;
    mm_start  = mul_state && !issued_q;
    mm_a      = '0;
    mm_b      = '0;
    case (state_q)
      TOBASE: begin mm_a = base_q;   mm_b = p_q;      end
      TOONE:  begin mm_a = MONT_ONE; mm_b = p_q;      end
      SQR:    begin mm_a = acc_q;    mm_b = acc_q;    end
      MUL:    begin mm_a = acc_q;    mm_b = xbar_q;   end
      FROM:   begin mm_a = acc_q;    mm_b = MONT_ONE; end
      default: begin mm_a = '0;      mm_b = '0;       end
    endcase
  end

  assign result  = result_q;
  assign err     = err_q;
  assign setup_n = n_q;
  assign mm_n    = n_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] n_i, base_i, exp_i;
  logic [15:0] result, setup_n, setup_p, mm_a, mm_b, mm_n, mm_r;
  logic        busy, done, err, setup_rst, setup_ce, setup_ready, mm_start, mm_done;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modexp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n(n_i), .base(base_i), .exp(exp_i),
    .result(result), .busy(busy), .done(done), .err(err),
    .setup_rst(setup_rst), .setup_ce(setup_ce), .setup_n(setup_n),
    .setup_p(setup_p), .setup_ready(setup_ready),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_r(mm_r)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nchecks++;
    if (act !== expv) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // a*b*2^-16 mod m by bitwise halving
  function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] m);
    logic [63:0] t;
    t = 64'(a) * 64'(b);
    for (int k = 0; k < 16; k++) begin
      if (t[0]) t = t + 64'(m);
      t = t >> 1;
    end
    return 16'(t % 64'(m));
  endfunction

  function automatic logic [15:0] ref_modexp(input logic [15:0] b, input logic [15:0] e,
                                             input logic [15:0] m);
    logic [63:0] r, x;
    r = 64'd1 % 64'(m);
    x = 64'(b) % 64'(m);
    for (int k = 0; k < 16; k++) begin
      if (e[k]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return 16'(r);
  endfunction

  // mm_setup model: p = 2^32 mod n after a random delay
  int setup_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      setup_ready <= 1'b0;
      setup_p     <= '0;
      setup_cnt   <= 0;
    end else if (setup_rst) begin
      setup_ready <= 1'b0;
      setup_cnt   <= $urandom_range(0, 5);
    end else if (setup_ce) begin
      if (setup_cnt == 0) begin
        setup_ready <= 1'b1;
        setup_p     <= 16'((64'd1 << 32) % 64'(setup_n));
      end else begin
        setup_cnt <= setup_cnt - 1;
      end
    end
  end

  // Montgomery multiplier model with random latency
  logic        mb_busy;
  int          mb_cnt;
  logic [15:0] mb_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_busy <= 1'b0;
      mb_cnt  <= 0;
      mb_res  <= '0;
      mm_done <= 1'b0;
      mm_r    <= '0;
    end else begin
      mm_done <= 1'b0;
      if (mb_busy) begin
        if (mb_cnt == 0) begin
          mm_done <= 1'b1;
          mm_r    <= mb_res;
          mb_busy <= 1'b0;
        end else begin
          mb_cnt <= mb_cnt - 1;
        end
      end else if (mm_start) begin
        mb_busy <= 1'b1;
        mb_cnt  <= $urandom_range(0, 4);
        mb_res  <= mont(mm_a, mm_b, mm_n);
      end
    end
  end

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          mmc;
    logic        setup;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  // monitor
  int          t0 = 0, mmc = 0, cec = 0;
  logic        pend = 1'b0;
  logic [15:0] cap_a = '0, cap_b = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mmc  = 0;
      cec  = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("issue_next_cycle", 64'(mm_start || done), 64'd1);
        pend = 1'b0;
      end
      if (start && !busy && !done) begin
        t0  = cyc;
        mmc = 0;
        cec = 0;
      end
      if (mm_start) begin
        mmc++;
        cap_a = mm_a;
        cap_b = mm_b;
      end
      if (setup_ce) cec++;
      if (mm_done) begin
        chk("mm_operands_hold", {32'd0, mm_a, mm_b}, {32'd0, cap_a, cap_b});
        pend = 1'b1;
      end
      if (setup_ready && setup_ce) pend = 1'b1;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("err", 64'(err), 64'(e.err));
          chk("mm_start_count", 64'(mmc), 64'(e.mmc));
          chk("setup_used", 64'(cec != 0), 64'(e.setup));
          chk("busy_with_done", 64'(busy), 64'd0);
          if (e.lat >= 0) chk("reject_latency", 64'(cyc - t0), 64'(e.lat));
        end
      end
    end
  end

  logic        tb_cache_vld = 1'b0;
  logic [15:0] tb_cache_n = '0;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_setup_rst"}, 64'(setup_rst), 64'd1);
    chk({tag, "_setup_ce"}, 64'(setup_ce), 64'd0);
    chk({tag, "_mm_start"}, 64'(mm_start), 64'd0);
    chk({tag, "_mm_a"}, 64'(mm_a), 64'd0);
    chk({tag, "_mm_b"}, 64'(mm_b), 64'd0);
  endtask

  task automatic pulse_start(input logic [15:0] nn, input logic [15:0] bb, input logic [15:0] ee);
    @(posedge clk); #1;
    start = 1'b1; n_i = nn; base_i = bb; exp_i = ee;
    @(posedge clk); #1;
    start = 1'b0;
    n_i = 16'($urandom); base_i = 16'($urandom); exp_i = 16'($urandom);
  endtask

  task automatic run_job(input logic [15:0] nn, input logic [15:0] bb, input logic [15:0] ee,
                         input bit poke);
    exp_t e;
    bit   bad, seen;
    bad     = !nn[0] || (nn < 16'd3);
    e.err   = bad;
    e.res   = bad ? 16'd0 : ref_modexp(bb, ee, nn);
    e.mmc   = bad ? 0 : 2 + 16 + $countones(ee) + 1;
    e.lat   = bad ? 2 : -1;
`ifdef MODEXP_SETUP_CACHE_EN
    e.setup = !bad && !(tb_cache_vld && tb_cache_n == nn);
    if (!bad) begin
      tb_cache_vld = 1'b1;
      tb_cache_n   = nn;
    end
`else
    e.setup = !bad;
`endif
    sbq.push_back(e);
    pulse_start(nn, bb, ee);
    if (poke) begin
      repeat (8) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic reset_mid_sqr();
    int  cnt;
    cnt = 0;
    pulse_start(16'h3317, 16'd2, 16'd10);
    for (int k = 0; k < 2000 && cnt < 3; k++) begin
      @(negedge clk);
      if (mm_start) cnt++;
    end
    if (cnt < 3) chk("reach_sqr_timeout", 64'(cnt), 64'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tb_cache_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] nn, bb, prev_n;
    rst = 1'b1; start = 1'b0; n_i = '0; base_i = '0; exp_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    run_job(16'h3317, 16'd2, 16'd10, 0);
    run_job(16'h3317, 16'd3, 16'd0, 0);
    run_job(16'h3316, 16'd5, 16'd7, 0);
    run_job(16'h3317, 16'h1234, 16'hFFFF, 1);
    run_job(16'h0001, 16'd0, 16'd3, 0);
    reset_mid_sqr();
    run_job(16'h3317, 16'd2, 16'd10, 0);
    run_job(16'h3317, 16'($urandom % 32'h3317), 16'($urandom), 0);

    prev_n = 16'h3317;
    for (int j = 0; j < 8; j++) begin
      nn = 16'($urandom) | 16'h0001;
      if (j == 3) nn = prev_n;
      if (j == 5) nn = nn & 16'hFFFE;
      bb = (nn == 16'd0) ? 16'd0 : 16'($urandom % 32'(nn));
      run_job(nn, bb, 16'($urandom), 0);
      prev_n = nn;
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
